// File: rtl/hemaia_superbank_arbiter.sv
// rtl/hemaia_superbank_arbiter.sv - per-superbank wide/narrow SRAM bank arbiter
//
// Arbitrates every SRAM bank of one superbank between a single wide requester
// (spanning all banks at a shared address) and one narrow requester per bank.
// The wide port wins by default; a starvation counter hands the cycle to the
// narrow side after MaxStall consecutive wide grants while narrow work waits.
// Read data returns one cycle after the grant and is routed by owner flags.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   wide_q_*                wide request (valid/ready, addr, write, data, strb)
//   wide_p_valid_o/data_o   wide read response
//   narrow_q_*              per-bank narrow requests
//   narrow_p_valid_o/data_o per-bank narrow read responses
//   bank_*                  SRAM bank ports (cs, we, addr, be, wdata, rdata)
module hemaia_superbank_arbiter #(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned AddrWidth       = 10,
  parameter int unsigned MaxStall        = 4
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         wide_q_valid_i,
  output logic                                         wide_q_ready_o,
  input  logic [AddrWidth-1:0]                         wide_q_addr_i,
  input  logic                                         wide_q_write_i,
  input  logic [WideDataWidth-1:0]                     wide_q_data_i,
  input  logic [WideDataWidth/8-1:0]                   wide_q_strb_i,
  output logic                                         wide_p_valid_o,
  output logic [WideDataWidth-1:0]                     wide_p_data_o,
  input  logic [WideDataWidth/NarrowDataWidth-1:0]     narrow_q_valid_i,
  output logic [WideDataWidth/NarrowDataWidth-1:0]     narrow_q_ready_o,
  input  logic [WideDataWidth/NarrowDataWidth*AddrWidth-1:0] narrow_q_addr_i,
  input  logic [WideDataWidth/NarrowDataWidth-1:0]     narrow_q_write_i,
  input  logic [WideDataWidth-1:0]                     narrow_q_data_i,
  input  logic [WideDataWidth/8-1:0]                   narrow_q_strb_i,
  output logic [WideDataWidth/NarrowDataWidth-1:0]     narrow_p_valid_o,
  output logic [WideDataWidth-1:0]                     narrow_p_data_o,
  output logic [WideDataWidth/NarrowDataWidth-1:0]     bank_cs_o,
  output logic [WideDataWidth/NarrowDataWidth-1:0]     bank_we_o,
  output logic [WideDataWidth/NarrowDataWidth*AddrWidth-1:0] bank_addr_o,
  output logic [WideDataWidth/8-1:0]                   bank_be_o,
  output logic [WideDataWidth-1:0]                     bank_wdata_o,
  input  logic [WideDataWidth-1:0]                     bank_rdata_i
);

  localparam int unsigned NumBanks  = WideDataWidth / NarrowDataWidth;
  localparam int unsigned StrbWidth = NarrowDataWidth / 8;
  localparam int unsigned CntWidth  = $clog2(MaxStall + 1);
  localparam logic [CntWidth-1:0] MaxStallCnt = CntWidth'(MaxStall);

  logic [CntWidth-1:0] stall_cnt;
  logic                rd_wide_q;
  logic [NumBanks-1:0] rd_narrow_q;
  logic                narrow_any;
  logic                wide_cycle;
  logic [NumBanks-1:0] narrow_grant;

  assign narrow_any = |narrow_q_valid_i;

  // Wide wins unless it has already held the banks MaxStall cycles in a row
  // while some narrow requester was waiting.
  assign wide_cycle   = !rst_i && wide_q_valid_i &&
                        ((stall_cnt < MaxStallCnt) || !narrow_any);
  assign narrow_grant = (rst_i || wide_cycle) ? '0 : narrow_q_valid_i;

  assign wide_q_ready_o   = wide_cycle;
  assign narrow_q_ready_o = narrow_grant;

  always_comb begin
    bank_cs_o    = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    for (int i = 0; i < NumBanks; i++) begin
      if (wide_cycle) begin
        bank_cs_o[i] = 1'b1;
        bank_we_o[i] = wide_q_write_i;
        bank_addr_o[i*AddrWidth +: AddrWidth]        = wide_q_addr_i;
        bank_be_o[i*StrbWidth +: StrbWidth]          = wide_q_strb_i[i*StrbWidth +: StrbWidth];
        bank_wdata_o[i*NarrowDataWidth +: NarrowDataWidth] =
          wide_q_data_i[i*NarrowDataWidth +: NarrowDataWidth];
      end else begin
        bank_cs_o[i] = narrow_grant[i];
        bank_we_o[i] = narrow_grant[i] & narrow_q_write_i[i];
        bank_addr_o[i*AddrWidth +: AddrWidth]        = narrow_q_addr_i[i*AddrWidth +: AddrWidth];
        bank_be_o[i*StrbWidth +: StrbWidth]          = narrow_q_strb_i[i*StrbWidth +: StrbWidth];
        bank_wdata_o[i*NarrowDataWidth +: NarrowDataWidth] =
          narrow_q_data_i[i*NarrowDataWidth +: NarrowDataWidth];
      end
    end
  end

  // A wide grant with narrow work pending can only happen below MaxStall,
  // so the increment never passes MaxStall and never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt   <= '0;
      rd_wide_q   <= 1'b0;
      rd_narrow_q <= '0;
    end else begin
      if (wide_cycle && narrow_any) begin
        stall_cnt <= stall_cnt + CntWidth'(1);
      end else begin
        stall_cnt <= '0;
      end
      rd_wide_q   <= wide_cycle && !wide_q_write_i;
      rd_narrow_q <= narrow_grant & ~narrow_q_write_i;
    end
  end

  // SRAM read data is valid one cycle after the read; the owner flags say
  // who issued it, so the data itself is simply fanned out to both sides.
  assign wide_p_valid_o   = rd_wide_q;
  assign wide_p_data_o    = bank_rdata_i;
  assign narrow_p_valid_o = rd_narrow_q;
  assign narrow_p_data_o  = bank_rdata_i;

endmodule

// File: tb/tb_hemaia_superbank_arbiter.sv
// tb/tb_hemaia_superbank_arbiter.sv - scoreboard bench for hemaia_superbank_arbiter
module tb_hemaia_superbank_arbiter;

  localparam int NW = 64;
  localparam int WW = 512;
  localparam int AW = 10;
  localparam int MS = 4;
  localparam int NB = WW / NW;
  localparam int SW = NW / 8;

  typedef struct {
    logic [WW-1:0] data;
    int            cyc;
  } resp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              wide_q_valid, wide_q_ready, wide_q_write;
  logic [AW-1:0]     wide_q_addr;
  logic [WW-1:0]     wide_q_data;
  logic [WW/8-1:0]   wide_q_strb;
  logic              wide_p_valid;
  logic [WW-1:0]     wide_p_data;
  logic [NB-1:0]     narrow_q_valid, narrow_q_ready, narrow_q_write, narrow_p_valid;
  logic [NB*AW-1:0]  narrow_q_addr;
  logic [WW-1:0]     narrow_q_data, narrow_p_data;
  logic [WW/8-1:0]   narrow_q_strb;
  logic [NB-1:0]     bank_cs, bank_we;
  logic [NB*AW-1:0]  bank_addr;
  logic [WW/8-1:0]   bank_be;
  logic [WW-1:0]     bank_wdata;
  logic [WW-1:0]     bank_rdata = '0;

  logic [NW-1:0] sram    [NB][1024];
  logic [NW-1:0] ref_mem [NB][1024];

  resp_t wq[$];
  resp_t nq[NB][$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int m_stall = 0;

  logic          last_wide_ready;
  logic          last_wide_pv;
  logic [WW-1:0] last_wide_pd;
  logic [NB-1:0] last_np_valid;
  logic [WW-1:0] last_np_data;

  hemaia_superbank_arbiter #(
    .NarrowDataWidth(NW), .WideDataWidth(WW), .AddrWidth(AW), .MaxStall(MS)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wide_q_valid_i(wide_q_valid), .wide_q_ready_o(wide_q_ready),
    .wide_q_addr_i(wide_q_addr), .wide_q_write_i(wide_q_write),
    .wide_q_data_i(wide_q_data), .wide_q_strb_i(wide_q_strb),
    .wide_p_valid_o(wide_p_valid), .wide_p_data_o(wide_p_data),
    .narrow_q_valid_i(narrow_q_valid), .narrow_q_ready_o(narrow_q_ready),
    .narrow_q_addr_i(narrow_q_addr), .narrow_q_write_i(narrow_q_write),
    .narrow_q_data_i(narrow_q_data), .narrow_q_strb_i(narrow_q_strb),
    .narrow_p_valid_o(narrow_p_valid), .narrow_p_data_o(narrow_p_data),
    .bank_cs_o(bank_cs), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
    .bank_be_o(bank_be), .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM bank model driven purely by the DUT bank ports.
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (bank_cs[i]) begin
        if (bank_we[i]) begin
          for (int b = 0; b < SW; b++)
            if (bank_be[i*SW+b])
              sram[i][bank_addr[i*AW +: AW]][b*8 +: 8] <= bank_wdata[i*NW + b*8 +: 8];
        end else begin
          bank_rdata[i*NW +: NW] <= sram[i][bank_addr[i*AW +: AW]];
        end
      end
    end
  end

  // Response monitor: pops the oldest expected response whenever a valid shows.
  always @(negedge clk) begin
    resp_t r;
    if (wide_p_valid) begin
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wide_resp_unexpected cyc=%0d", cyc);
      end else begin
        r = wq.pop_front();
        if (r.cyc != cyc || wide_p_data !== r.data) begin
          n_fail++;
          $display("FAIL wide_resp cyc=%0d exp_cyc=%0d got=%h exp=%h", cyc, r.cyc, wide_p_data, r.data);
        end
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (narrow_p_valid[i]) begin
        n_tests++;
        if (nq[i].size() == 0) begin
          n_fail++;
          $display("FAIL narrow_resp_unexpected bank=%0d cyc=%0d", i, cyc);
        end else begin
          r = nq[i].pop_front();
          if (r.cyc != cyc || narrow_p_data[i*NW +: NW] !== r.data[NW-1:0]) begin
            n_fail++;
            $display("FAIL narrow_resp bank=%0d cyc=%0d exp_cyc=%0d got=%h exp=%h",
                     i, cyc, r.cyc, narrow_p_data[i*NW +: NW], r.data[NW-1:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model: grant decision from the priority/starvation rules,
  // memory contents tracked as plain arrays, expected reads queued.
  task automatic model_cycle();
    logic          exp_w;
    logic [NB-1:0] exp_n;
    resp_t         r;
    exp_w = !rst && wide_q_valid && (m_stall < MS || narrow_q_valid == '0);
    exp_n = (rst || exp_w) ? '0 : narrow_q_valid;
    check("grant", WW'({wide_q_ready, narrow_q_ready}), WW'({exp_w, exp_n}));
    check("bank_cs", WW'(bank_cs), WW'(exp_w ? {NB{1'b1}} : exp_n));
    if (exp_w) begin
      if (wide_q_write) begin
        for (int i = 0; i < NB; i++)
          for (int b = 0; b < SW; b++)
            if (wide_q_strb[i*SW+b])
              ref_mem[i][wide_q_addr][b*8 +: 8] = wide_q_data[i*NW + b*8 +: 8];
      end else begin
        r.data = '0;
        for (int i = 0; i < NB; i++) r.data[i*NW +: NW] = ref_mem[i][wide_q_addr];
        r.cyc = cyc + 1;
        wq.push_back(r);
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (exp_n[i]) begin
        if (narrow_q_write[i]) begin
          for (int b = 0; b < SW; b++)
            if (narrow_q_strb[i*SW+b])
              ref_mem[i][narrow_q_addr[i*AW +: AW]][b*8 +: 8] = narrow_q_data[i*NW + b*8 +: 8];
        end else begin
          r.data = '0;
          r.data[NW-1:0] = ref_mem[i][narrow_q_addr[i*AW +: AW]];
          r.cyc = cyc + 1;
          nq[i].push_back(r);
        end
      end
    end
    if (rst) m_stall = 0;
    else if (exp_w && narrow_q_valid != '0) m_stall = m_stall + 1;
    else m_stall = 0;
  endtask

  task automatic step();
    @(negedge clk);
    last_wide_ready = wide_q_ready;
    last_wide_pv    = wide_p_valid;
    last_wide_pd    = wide_p_data;
    last_np_valid   = narrow_p_valid;
    last_np_data    = narrow_p_data;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0;
    wide_q_valid = 1'b0; wide_q_write = 1'b0; wide_q_addr = '0;
    wide_q_data = '0; wide_q_strb = '0;
    narrow_q_valid = '0; narrow_q_write = '0; narrow_q_addr = '0;
    narrow_q_data = '0; narrow_q_strb = '0;
  endtask

  initial begin
    logic [NW-1:0] pat;
    for (int i = 0; i < NB; i++)
      for (int a = 0; a < 1024; a++) begin
        sram[i][a] = '0;
        ref_mem[i][a] = '0;
      end
    set_idle();

    // Reset held two cycles with every valid asserted.
    rst = 1'b1; wide_q_valid = 1'b1; narrow_q_valid = '1;
    step(); step();
    check("reset_p_valid", WW'({last_wide_pv, last_np_valid}), '0);
    rst = 1'b0;
    step();
    check("post_reset_wide_first", WW'(last_wide_ready), WW'(1));
    set_idle(); step(); step();

    // Wide write/read round trip at 0x10.
    wide_q_valid = 1'b1; wide_q_write = 1'b1; wide_q_addr = 10'h10; wide_q_strb = '1;
    for (int i = 0; i < NB; i++) wide_q_data[i*NW +: NW] = {8{8'(i)}};
    step();
    wide_q_write = 1'b0;
    step();
    set_idle();
    step();
    check("roundtrip_valid", WW'({last_wide_pv, last_np_valid}), WW'({1'b1, {NB{1'b0}}}));
    for (int i = 0; i < NB; i++) begin
      pat = {8{8'(i)}};
      check("roundtrip_slice", WW'(last_wide_pd[i*NW +: NW]), WW'(pat));
    end

    // Narrow independence: prime banks 0/3, then read both together.
    narrow_q_valid = 8'b0000_1001; narrow_q_write = 8'b0000_1001; narrow_q_strb = '1;
    narrow_q_addr[0*AW +: AW] = 10'h5; narrow_q_addr[3*AW +: AW] = 10'h7;
    narrow_q_data[0*NW +: NW] = 64'hA5A5_0000_1111_0005;
    narrow_q_data[3*NW +: NW] = 64'h5A5A_3333_2222_0007;
    step();
    narrow_q_write = '0;
    step();
    set_idle();
    step();
    check("narrow_pvalid", WW'(last_np_valid), WW'(8'b0000_1001));
    check("narrow_b0", WW'(last_np_data[0*NW +: NW]), WW'(64'hA5A5_0000_1111_0005));
    check("narrow_b3", WW'(last_np_data[3*NW +: NW]), WW'(64'h5A5A_3333_2222_0007));

    // Starvation: wide streams, bank 2 waits; narrow every fifth cycle.
    for (int k = 0; k < 15; k++) begin
      wide_q_valid = 1'b1; wide_q_write = 1'b0; wide_q_addr = 10'(k);
      narrow_q_valid = 8'b0000_0100; narrow_q_addr[2*AW +: AW] = 10'(k + 3);
      step();
      check("starve_pattern", WW'(last_wide_ready), WW'((k % 5) != 4));
    end
    set_idle(); step();

    // Wide stream without narrow traffic.
    for (int k = 0; k < 20; k++) begin
      wide_q_valid = 1'b1; wide_q_write = 1'b0; wide_q_addr = 10'(k);
      step();
      check("wide_only_grant", WW'(last_wide_ready), WW'(1));
    end
    set_idle(); step();

    // Reset coinciding with a wide read: no grant, no response.
    wide_q_valid = 1'b1; wide_q_addr = 10'h10; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    set_idle();
    step();
    check("post_reset_read_valid", WW'(last_wide_pv), WW'(1));
    check("post_reset_read_data", WW'(last_wide_pd[5*NW +: NW]), WW'({8{8'h05}}));

    // Randomized traffic over a small address window to force collisions.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) < 2);
      wide_q_valid = ($urandom_range(0, 99) < 55);
      wide_q_write = $urandom_range(0, 1);
      wide_q_addr = 10'($urandom_range(0, 15));
      for (int j = 0; j < WW / 32; j++) begin
        wide_q_data[j*32 +: 32] = $urandom;
        narrow_q_data[j*32 +: 32] = $urandom;
      end
      wide_q_strb = {$urandom, $urandom};
      narrow_q_strb = {$urandom, $urandom};
      narrow_q_valid = 8'($urandom) & 8'($urandom);
      narrow_q_write = 8'($urandom);
      for (int i = 0; i < NB; i++) narrow_q_addr[i*AW +: AW] = 10'($urandom_range(0, 15));
      step();
    end
    set_idle();
    step(); step(); step();

    check("wide_queue_drained", WW'(wq.size()), '0);
    for (int i = 0; i < NB; i++) check("narrow_queue_drained", WW'(nq[i].size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
